game_sprite_mover: RTL
======================

// Module: game_sprite_mover
// PURPOSE
//  Per-sprite position/velocity engine; the responder to the game master FSM's sprite controls.
//  - Accepts write_xy / write_dxy / enable_update and returns within_screen.
//  - Moves the sprite once every FRAMES_PER_STEP frame ticks while updates are enabled.
//  - Flags the current raster pixel for display and collision logic.
//  - One instance per sprite (targets, bullet, spaceship, hearts).
// PARAMETERS
//  X_WIDTH          10   width of x position, unsigned
//  Y_WIDTH          10   width of y position, unsigned
//  DX_WIDTH          4   width of dx, two's complement
//  DY_WIDTH          4   width of dy, two's complement
//  SPRITE_WIDTH      8   sprite bounding-box width, pixels
//  SPRITE_HEIGHT     8   sprite bounding-box height, pixels
//  SCREEN_WIDTH    640   visible width
//  SCREEN_HEIGHT   480   visible height
//  FRAMES_PER_STEP   2   frame ticks per motion step, >=1
// PORTS
//  clk            in   1        system clock
//  rst            in   1        asynchronous, active-high reset
//  write_xy       in   1        load x_in/y_in this cycle
//  x_in           in   X_WIDTH  new x
//  y_in           in   Y_WIDTH  new y
//  write_dxy      in   1        load dx_in/dy_in this cycle
//  dx_in          in   DX_WIDTH new signed dx
//  dy_in          in   DY_WIDTH new signed dy
//  enable_update  in   1        motion enabled (level)
//  frame_tick     in   1        1-cycle pulse, once per frame (vblank start)
//  pixel_x        in   X_WIDTH  current raster x
//  pixel_y        in   Y_WIDTH  current raster y
//  x              out  X_WIDTH  current position, top-left
//  y              out  Y_WIDTH  current position, top-left
//  within_screen  out  1        whole box on screen
//  stepped        out  1        1-cycle pulse after each motion step
//  pixel_hit      out  1        raster pixel inside box, registered
// BEHAVIOUR
//  - Reset values: x=0, y=0, dx=0, dy=0, divider count=0, stepped=0, pixel_hit=0.
//    within_screen is therefore 1 out of reset.
//  - Divider count:
//    - Held at 0 while enable_update=0.
//    - Cleared on write_xy.
//    - Otherwise increments on frame_tick while enable_update=1.
//  - Step:
//    - Occurs on a frame_tick with enable_update=1 and count==FRAMES_PER_STEP-1.
//    - Count returns to 0 on a step.
//    - x <= x + sext(dx), y <= y + sext(dy), computed modulo 2^X_WIDTH and 2^Y_WIDTH.
//    - Wrap-around is intentional: moving off left or top yields a huge value, so within_screen=0.
//    - stepped=1 in the following cycle.
//  - Priority in the same cycle:
//    - write_xy beats a step: position loads x_in/y_in, no step occurs, stepped stays 0.
//    - write_dxy with a step: the step uses the OLD dx/dy; the new velocity applies from the next step.
//    - write_xy and write_dxy together both take effect.
//  - within_screen is combinational from the registered x/y (zero latency w.r.t. x/y):
//    (x + SPRITE_WIDTH <= SCREEN_WIDTH) && (y + SPRITE_HEIGHT <= SCREEN_HEIGHT).
//    Sums are evaluated one bit wider than the position width, so there is no overflow alias.
//  - pixel_hit = registered (pixel_x - x < SPRITE_WIDTH) && (pixel_y - y < SPRITE_HEIGHT).
//    - Unsigned differences; latency 1 cycle.
//    - Uses the x/y values as they stand before the current cycle's write/step.
//  - enable_update falling mid-count: count clears; the next enable restarts a full FRAMES_PER_STEP wait.
//  - Asynchronous rst at any time returns all state to the reset values; no partial step survives.
// STRUCTURE
//  - Screen size and the sprite coordinate widths are shared constants in game_config.svh;
//    parameter defaults take them from there.
//  - Sub-module game_sprite_frame_divider:
//    - Inputs: frame_tick, enable, clear.
//    - Output: step pulse.
//    - Holds the FRAMES_PER_STEP counter.
//  - Top level holds the x/y/dx/dy registers, the bounds compare and the pixel_hit register.
// TESTING
//  1. Reset, then write_xy x_in=100 y_in=50 and write_dxy dx=+2 dy=-1, enable_update=1, 4 frame_ticks
//     -> two steps; x=104, y=48, stepped pulses twice.
//  2. x=630, dx=+2, SPRITE_WIDTH=8, 1 step -> x=632, within_screen=1; next step -> x=634, within_screen=0.
//  3. x=1, dx=-2 -> after one step x=1023, within_screen=0 (wrap).
//  4. write_xy asserted in the same cycle as a step tick -> x/y equal x_in/y_in, stepped=0, count=0.
//  5. enable_update dropped after 1 of 2 ticks, then re-raised -> 2 further ticks needed before the next step.
//  6. x=100, y=50, raster sweeps pixel_x 99..108 at pixel_y=50 -> pixel_hit is 1 exactly for 100..107,
//     one cycle late.

Source files
------------

// File: rtl/game_sprite_mover_pkg.sv
// Shared constants and helpers for the sprite mover and its frame divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_sprite_mover_pkg;

    `include "game_config.svh"

    localparam int SPRITE_W_DEFAULT        = 8;
    localparam int SPRITE_H_DEFAULT        = 8;
    localparam int FRAMES_PER_STEP_DEFAULT = 2;

    // Counter width for a modulo-n count; never below one bit so n=1 still builds.
    function automatic int count_width(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : 1;
        return w;
    endfunction

endpackage

// File: rtl/game_config.svh
// Shared game geometry: screen size and sprite coordinate widths.
// Included inside game_sprite_mover_pkg so every sprite instance agrees on them.
// Values only; no logic lives here.
`ifndef GAME_CONFIG_SVH
`define GAME_CONFIG_SVH

localparam int GAME_SCREEN_WIDTH  = 640;
localparam int GAME_SCREEN_HEIGHT = 480;
localparam int GAME_X_WIDTH       = 10;
localparam int GAME_Y_WIDTH       = 10;
localparam int GAME_DX_WIDTH      = 4;
localparam int GAME_DY_WIDTH      = 4;

`endif

// File: rtl/game_sprite_frame_divider.sv
// Counts frame ticks and emits a step pulse every FRAMES_PER_STEP ticks while enabled.
// Latency: step is combinational in the cycle of the qualifying frame_tick.
// Backpressure: none; clear or enable low discards any partial count.
// Ports: clk, rst (async active-high), frame_tick, enable (level), clear (1-cycle), step (out).
module game_sprite_frame_divider
    import game_sprite_mover_pkg::*;
#(
    parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int CW = count_width(FRAMES_PER_STEP);
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          at_last;

    assign at_last = (count_q == LAST);

    // A clear (position reload) suppresses the step so the new position is not moved.
    assign step = enable && frame_tick && !clear && at_last;

    always_comb begin
        count_d = count_q;
        if (!enable || clear) begin
            count_d = '0;
        end else if (frame_tick) begin
            count_d = at_last ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_sprite_mover.sv
// Per-sprite position/velocity engine: loads, steps on divided frame ticks, bounds and raster hit.
// Latency: x/y/stepped/pixel_hit registered (1 cycle); within_screen combinational from x/y.
// Backpressure: none; write_xy wins over a coincident step, write_dxy applies from the next step.
// Ports: clk, rst (async active-high); write_xy/x_in/y_in, write_dxy/dx_in/dy_in, enable_update,
//        frame_tick, pixel_x/pixel_y in; x, y, within_screen, stepped, pixel_hit out.
module game_sprite_mover
    import game_sprite_mover_pkg::*;
#(
    parameter int X_WIDTH         = GAME_X_WIDTH,
    parameter int Y_WIDTH         = GAME_Y_WIDTH,
    parameter int DX_WIDTH        = GAME_DX_WIDTH,
    parameter int DY_WIDTH        = GAME_DY_WIDTH,
    parameter int SPRITE_WIDTH    = SPRITE_W_DEFAULT,
    parameter int SPRITE_HEIGHT   = SPRITE_H_DEFAULT,
    parameter int SCREEN_WIDTH    = GAME_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT   = GAME_SCREEN_HEIGHT,
    parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_xy,
    input  logic [X_WIDTH-1:0] x_in,
    input  logic [Y_WIDTH-1:0] y_in,
    input  logic               write_dxy,
    input  logic [DX_WIDTH-1:0] dx_in,
    input  logic [DY_WIDTH-1:0] dy_in,
    input  logic               enable_update,
    input  logic               frame_tick,
    input  logic [X_WIDTH-1:0] pixel_x,
    input  logic [Y_WIDTH-1:0] pixel_y,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               within_screen,
    output logic               stepped,
    output logic               pixel_hit
);

    localparam int XE = X_WIDTH - DX_WIDTH;
    localparam int YE = Y_WIDTH - DY_WIDTH;

    logic [X_WIDTH-1:0]  x_q, x_d;
    logic [Y_WIDTH-1:0]  y_q, y_d;
    logic [DX_WIDTH-1:0] dx_q, dx_d;
    logic [DY_WIDTH-1:0] dy_q, dy_d;
    logic                stepped_q, stepped_d;
    logic                pixel_hit_q, pixel_hit_d;

    logic                step;
    logic [X_WIDTH-1:0]  dx_ext;
    logic [Y_WIDTH-1:0]  dy_ext;
    logic [X_WIDTH-1:0]  rel_x;
    logic [Y_WIDTH-1:0]  rel_y;
    logic [X_WIDTH:0]    x_end;
    logic [Y_WIDTH:0]    y_end;

    game_sprite_frame_divider #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_divider (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .enable     (enable_update),
        .clear      (write_xy),
        .step       (step)
    );

    // Sign-extend velocity; the add then wraps modulo 2^width, so moving off the
    // left/top edge lands on a large value that the bounds check rejects.
    assign dx_ext = {{XE{dx_q[DX_WIDTH-1]}}, dx_q};
    assign dy_ext = {{YE{dy_q[DY_WIDTH-1]}}, dy_q};

    // One bit wider than the position so x+width cannot alias back on screen.
    assign x_end = {1'b0, x_q} + (X_WIDTH+1)'(SPRITE_WIDTH);
    assign y_end = {1'b0, y_q} + (Y_WIDTH+1)'(SPRITE_HEIGHT);
    assign within_screen = (x_end <= (X_WIDTH+1)'(SCREEN_WIDTH)) &&
                           (y_end <= (Y_WIDTH+1)'(SCREEN_HEIGHT));

    // Unsigned difference folds both "left of box" and "right of box" into one compare.
    assign rel_x = pixel_x - x_q;
    assign rel_y = pixel_y - y_q;

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        stepped_d   = step;
        pixel_hit_d = (rel_x < X_WIDTH'(SPRITE_WIDTH)) && (rel_y < Y_WIDTH'(SPRITE_HEIGHT));

        if (write_xy) begin
            x_d = x_in;
            y_d = y_in;
        end else if (step) begin
            // Uses the velocity held before any same-cycle write_dxy.
            x_d = x_q + dx_ext;
            y_d = y_q + dy_ext;
        end

        if (write_dxy) begin
            dx_d = dx_in;
            dy_d = dy_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            stepped_q   <= 1'b0;
            pixel_hit_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            stepped_q   <= stepped_d;
            pixel_hit_q <= pixel_hit_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign stepped   = stepped_q;
    assign pixel_hit = pixel_hit_q;

endmodule
